// File: rtl/controle_preparo.sv
// controle_preparo: brew sequencer that sits after the drink-selection FSM.
// Generates the selection-timeout pulse for the selector, latches the chosen
// drink code on a fresh "chosen" edge and drives heater, dosers and valves
// through a fixed recipe, reporting busy / ready / error to the panel.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   Escolha[1:0]        selector status: 00 idle, 01 selecting, 10 timeout, 11 chosen
//   Bebida[3:0]         drink code: 1 espresso, 2 cafe com leite, 3 cha, 4 cappuccino
//   Agua_Quente, Copo   water-hot sensor, cup present
//   Cancela             user cancel / error acknowledge
//   Timer               selection timeout back to the selector
//   Aquecedor, Dosador_Cafe, Dosador_Cha, Valvula_Agua, Valvula_Leite  actuators
//   Ocupado, Pronto, Erro  panel status
//   Etapa[2:0]          current state encoding for display
module controle_preparo #(
  parameter int unsigned TIMEOUT_SEL = 64,
  parameter int unsigned T_PO        = 3,
  parameter int unsigned T_AGUA      = 8,
  parameter int unsigned T_LEITE     = 4,
  parameter int unsigned T_AQUEC_MAX = 32,
  parameter int unsigned T_PRONTO    = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] Escolha,
  input  logic [3:0] Bebida,
  input  logic       Agua_Quente,
  input  logic       Copo,
  input  logic       Cancela,
  output logic       Timer,
  output logic       Aquecedor,
  output logic       Dosador_Cafe,
  output logic       Dosador_Cha,
  output logic       Valvula_Agua,
  output logic       Valvula_Leite,
  output logic       Ocupado,
  output logic       Pronto,
  output logic       Erro,
  output logic [2:0] Etapa
);

  // Wide enough for the longest single step with margin.
  localparam int unsigned W_PASSO = $clog2(T_AQUEC_MAX + 2*T_LEITE + T_AGUA + T_PO + T_PRONTO + 1);
  localparam int unsigned W_TMR   = $clog2(TIMEOUT_SEL + 1);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    AQUECE = 3'd1,
    DOSA   = 3'd2,
    AGUA   = 3'd3,
    LEITE  = 3'd4,
    PRONTO = 3'd5,
    ERRO   = 3'd6
  } estado_t;

  estado_t              r_estado;
  estado_t              w_prox;
  logic [W_PASSO-1:0]   r_passo;
  logic [W_PASSO-1:0]   w_passo_prox;
  logic [W_PASSO-1:0]   w_fim_leite;
  logic [W_TMR-1:0]     r_tmr;
  logic [W_TMR-1:0]     w_tmr_prox;
  logic [3:0]           r_codigo;
  logic [3:0]           w_codigo_prox;
  logic                 r_esc11_ant;
  logic                 w_inicio;
  logic                 w_conta;
  logic                 w_codigo_ok;

  assign w_inicio    = (Escolha == 2'b11) && !r_esc11_ant;
  assign w_conta     = (Escolha == 2'b01) && (r_estado == OCIOSO);
  assign w_codigo_ok = (Bebida >= 4'd1) && (Bebida <= 4'd4);
  assign w_fim_leite = (r_codigo == 4'd4) ? W_PASSO'(2*T_LEITE - 1) : W_PASSO'(T_LEITE - 1);

  // Next state: cup loss beats cancel, cancel beats the step timer.
  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      OCIOSO: begin
        if (w_inicio)                   w_prox = w_codigo_ok ? AQUECE : ERRO;
        else if (Escolha == 2'b10)      w_prox = ERRO;
      end
      AQUECE: begin
        if (Cancela)                    w_prox = OCIOSO;
        else if (Agua_Quente && Copo)   w_prox = DOSA;
        else if (r_passo == W_PASSO'(T_AQUEC_MAX - 1)) w_prox = ERRO;
      end
      DOSA: begin
        if (!Copo)                      w_prox = ERRO;
        else if (Cancela)               w_prox = OCIOSO;
        else if (r_passo == W_PASSO'(T_PO - 1)) w_prox = AGUA;
      end
      AGUA: begin
        if (!Copo)                      w_prox = ERRO;
        else if (Cancela)               w_prox = OCIOSO;
        else if (r_passo == W_PASSO'(T_AGUA - 1))
          w_prox = ((r_codigo == 4'd2) || (r_codigo == 4'd4)) ? LEITE : PRONTO;
      end
      LEITE: begin
        if (!Copo)                      w_prox = ERRO;
        else if (Cancela)               w_prox = OCIOSO;
        else if (r_passo == w_fim_leite) w_prox = PRONTO;
      end
      PRONTO: begin
        if (r_passo == W_PASSO'(T_PRONTO - 1)) w_prox = OCIOSO;
      end
      ERRO: begin
        if (Cancela)                    w_prox = OCIOSO;
      end
      default:                          w_prox = OCIOSO;
    endcase
  end

  always_comb begin
    w_passo_prox  = (w_prox != r_estado) ? '0 : r_passo + 1'b1;
    w_codigo_prox = ((r_estado == OCIOSO) && w_inicio) ? Bebida : r_codigo;
    w_tmr_prox    = '0;
    if (w_conta)
      w_tmr_prox = (r_tmr == W_TMR'(TIMEOUT_SEL - 1)) ? r_tmr : r_tmr + 1'b1;
  end

  // Outputs are decoded from the state being entered, so once registered
  // they line up with r_estado.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_estado      <= OCIOSO;
      r_passo       <= '0;
      r_tmr         <= '0;
      r_codigo      <= '0;
      r_esc11_ant   <= 1'b0;
      Timer         <= 1'b0;
      Aquecedor     <= 1'b0;
      Dosador_Cafe  <= 1'b0;
      Dosador_Cha   <= 1'b0;
      Valvula_Agua  <= 1'b0;
      Valvula_Leite <= 1'b0;
      Ocupado       <= 1'b0;
      Pronto        <= 1'b0;
      Erro          <= 1'b0;
      Etapa         <= '0;
    end else begin
      r_estado      <= w_prox;
      r_passo       <= w_passo_prox;
      r_tmr         <= w_tmr_prox;
      r_codigo      <= w_codigo_prox;
      r_esc11_ant   <= (Escolha == 2'b11);
      Timer         <= w_conta && (w_tmr_prox == W_TMR'(TIMEOUT_SEL - 1));
      Aquecedor     <= (w_prox == AQUECE) || (w_prox == DOSA) || (w_prox == AGUA);
      Dosador_Cafe  <= (w_prox == DOSA) && (w_codigo_prox != 4'd3);
      Dosador_Cha   <= (w_prox == DOSA) && (w_codigo_prox == 4'd3);
      Valvula_Agua  <= (w_prox == AGUA);
      Valvula_Leite <= (w_prox == LEITE);
      Ocupado       <= (w_prox == AQUECE) || (w_prox == DOSA) ||
                       (w_prox == AGUA)   || (w_prox == LEITE);
      Pronto        <= (w_prox == PRONTO);
      Erro          <= (w_prox == ERRO);
      Etapa         <= w_prox;
    end
  end

endmodule

// File: tb/tb_controle_preparo.sv
module tb_controle_preparo;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] Escolha;
  logic [3:0] Bebida;
  logic       Agua_Quente, Copo, Cancela;
  logic       Timer, Aquecedor, Dosador_Cafe, Dosador_Cha;
  logic       Valvula_Agua, Valvula_Leite, Ocupado, Pronto, Erro;
  logic [2:0] Etapa;

  int n_tests = 0;
  int n_fail  = 0;

  // cycle counts gathered while a brew runs to completion
  int c_aq, c_cafe, c_cha, c_agua, c_leite, c_ocup, c_pronto;

  controle_preparo #(
    .TIMEOUT_SEL(64), .T_PO(3), .T_AGUA(8), .T_LEITE(4), .T_AQUEC_MAX(32), .T_PRONTO(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .Escolha(Escolha), .Bebida(Bebida),
    .Agua_Quente(Agua_Quente), .Copo(Copo), .Cancela(Cancela),
    .Timer(Timer), .Aquecedor(Aquecedor), .Dosador_Cafe(Dosador_Cafe),
    .Dosador_Cha(Dosador_Cha), .Valvula_Agua(Valvula_Agua),
    .Valvula_Leite(Valvula_Leite), .Ocupado(Ocupado), .Pronto(Pronto),
    .Erro(Erro), .Etapa(Etapa)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [11:0] saidas();
    return {Timer, Aquecedor, Dosador_Cafe, Dosador_Cha, Valvula_Agua,
            Valvula_Leite, Ocupado, Pronto, Erro, Etapa};
  endfunction

  // fresh 00 -> 11 edge with the given code; returns one cycle after the edge
  task automatic iniciar(input logic [3:0] code);
    Escolha = 2'b00;
    tick();
    Bebida  = code;
    Escolha = 2'b11;
    tick();
  endtask

  // count active cycles of each output until the machine is back in OCIOSO
  task automatic medir();
    c_aq = 0; c_cafe = 0; c_cha = 0; c_agua = 0; c_leite = 0; c_ocup = 0; c_pronto = 0;
    for (int i = 0; i < 200; i++) begin
      if (Aquecedor)     c_aq++;
      if (Dosador_Cafe)  c_cafe++;
      if (Dosador_Cha)   c_cha++;
      if (Valvula_Agua)  c_agua++;
      if (Valvula_Leite) c_leite++;
      if (Ocupado)       c_ocup++;
      if (Pronto)        c_pronto++;
      if (Etapa == 3'd0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; Escolha = 2'b00; Bebida = 4'd0;
    Agua_Quente = 1'b0; Copo = 1'b0; Cancela = 1'b0;
    #23;
    n_tests++;
    if (saidas() !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", saidas(), 12'h000);
    end
    RST_N = 1'b1;
    tick();
    n_tests++;
    if (saidas() !== 12'h000) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", saidas(), 12'h000);
    end
  endtask

  task automatic test_timer();
    Escolha = 2'b01;
    for (int k = 1; k <= 64; k++) begin
      tick();
      n_tests++;
      if (Timer !== (k >= 63)) begin
        n_fail++; $display("FAIL timer_cycle_%0d: got %b expected %b", k, Timer, (k >= 63));
      end
    end
    Escolha = 2'b10;
    tick();
    n_tests++;
    if (Etapa !== 3'd6 || Erro !== 1'b1 || Timer !== 1'b0) begin
      n_fail++; $display("FAIL timeout_erro: etapa=%0d erro=%b timer=%b expected 6 1 0", Etapa, Erro, Timer);
    end
    Cancela = 1'b1; Escolha = 2'b00;
    tick();
    Cancela = 1'b0;
    n_tests++;
    if (Etapa !== 3'd0 || Erro !== 1'b0) begin
      n_fail++; $display("FAIL erro_ack: etapa=%0d erro=%b expected 0 0", Etapa, Erro);
    end
  endtask

  task automatic test_invalid_code();
    iniciar(4'd0);
    n_tests++;
    if (Etapa !== 3'd6 || Erro !== 1'b1 || Ocupado !== 1'b0) begin
      n_fail++; $display("FAIL code0_erro: etapa=%0d erro=%b ocup=%b expected 6 1 0", Etapa, Erro, Ocupado);
    end
    Cancela = 1'b1; tick(); Cancela = 1'b0;
    iniciar(4'd5);
    n_tests++;
    if (Etapa !== 3'd6) begin
      n_fail++; $display("FAIL code5_erro: etapa=%0d expected 6", Etapa);
    end
    Cancela = 1'b1; tick(); Cancela = 1'b0;
  endtask

  task automatic test_espresso();
    Copo = 1'b1; Agua_Quente = 1'b0;
    iniciar(4'd1);
    n_tests++;
    if (Etapa !== 3'd1 || Aquecedor !== 1'b1 || Ocupado !== 1'b1) begin
      n_fail++; $display("FAIL espresso_aquece: etapa=%0d aq=%b ocup=%b expected 1 1 1", Etapa, Aquecedor, Ocupado);
    end
    for (int k = 0; k < 4; k++) tick();
    n_tests++;
    if (Etapa !== 3'd1) begin
      n_fail++; $display("FAIL espresso_wait_hot: etapa=%0d expected 1", Etapa);
    end
    Agua_Quente = 1'b1;
    medir();
    n_tests++;
    if (c_cafe !== 3 || c_cha !== 0 || c_agua !== 8 || c_leite !== 0 || c_pronto !== 4) begin
      n_fail++; $display("FAIL espresso_recipe: cafe=%0d cha=%0d agua=%0d leite=%0d pronto=%0d expected 3 0 8 0 4",
                         c_cafe, c_cha, c_agua, c_leite, c_pronto);
    end
    n_tests++;
    if (c_aq !== 12 || c_ocup !== 12 || Etapa !== 3'd0) begin
      n_fail++; $display("FAIL espresso_heat_end: aq=%0d ocup=%0d etapa=%0d expected 12 12 0", c_aq, c_ocup, Etapa);
    end
    // Escolha still held at 11: no second brew
    for (int k = 0; k < 6; k++) tick();
    n_tests++;
    if (Etapa !== 3'd0 || Ocupado !== 1'b0) begin
      n_fail++; $display("FAIL steady_11_no_rebrew: etapa=%0d ocup=%b expected 0 0", Etapa, Ocupado);
    end
  endtask

  task automatic test_milk_drinks();
    iniciar(4'd4);
    medir();
    n_tests++;
    if (c_leite !== 8 || c_agua !== 8 || c_cafe !== 3 || c_pronto !== 4 || c_aq !== 12) begin
      n_fail++; $display("FAIL cappuccino: leite=%0d agua=%0d cafe=%0d pronto=%0d aq=%0d expected 8 8 3 4 12",
                         c_leite, c_agua, c_cafe, c_pronto, c_aq);
    end
    iniciar(4'd2);
    medir();
    n_tests++;
    if (c_leite !== 4 || c_agua !== 8 || c_cafe !== 3 || c_ocup !== 16) begin
      n_fail++; $display("FAIL cafe_com_leite: leite=%0d agua=%0d cafe=%0d ocup=%0d expected 4 8 3 16",
                         c_leite, c_agua, c_cafe, c_ocup);
    end
  endtask

  task automatic test_cha();
    iniciar(4'd3);
    medir();
    n_tests++;
    if (c_cha !== 3 || c_cafe !== 0 || c_leite !== 0 || c_agua !== 8 || c_pronto !== 4) begin
      n_fail++; $display("FAIL cha: cha=%0d cafe=%0d leite=%0d agua=%0d pronto=%0d expected 3 0 0 8 4",
                         c_cha, c_cafe, c_leite, c_agua, c_pronto);
    end
  endtask

  task automatic test_aquec_timeout();
    Agua_Quente = 1'b0;
    iniciar(4'd1);
    for (int k = 0; k < 31; k++) tick();
    n_tests++;
    if (Etapa !== 3'd1 || Aquecedor !== 1'b1) begin
      n_fail++; $display("FAIL aquece_cycle_32: etapa=%0d aq=%b expected 1 1", Etapa, Aquecedor);
    end
    tick();
    n_tests++;
    if (Etapa !== 3'd6 || Erro !== 1'b1 || Aquecedor !== 1'b0) begin
      n_fail++; $display("FAIL aquece_timeout: etapa=%0d erro=%b aq=%b expected 6 1 0", Etapa, Erro, Aquecedor);
    end
    Cancela = 1'b1; tick(); Cancela = 1'b0;
    Agua_Quente = 1'b1;
  endtask

  task automatic test_copo_loss();
    iniciar(4'd1);
    for (int k = 0; k < 6; k++) tick();   // 1 AQUECE + 3 DOSA -> AGUA, then 2 more
    n_tests++;
    if (Etapa !== 3'd3 || Valvula_Agua !== 1'b1) begin
      n_fail++; $display("FAIL copo_pre_agua: etapa=%0d agua=%b expected 3 1", Etapa, Valvula_Agua);
    end
    Copo = 1'b0;
    tick();
    n_tests++;
    if (Valvula_Agua !== 1'b0 || Erro !== 1'b1 || Aquecedor !== 1'b0 || Etapa !== 3'd6) begin
      n_fail++; $display("FAIL copo_loss: agua=%b erro=%b aq=%b etapa=%0d expected 0 1 0 6",
                         Valvula_Agua, Erro, Aquecedor, Etapa);
    end
    Copo = 1'b1; Cancela = 1'b1; tick(); Cancela = 1'b0;
  endtask

  task automatic test_cancel();
    iniciar(4'd1);
    tick();                               // DOSA
    Cancela = 1'b1;
    tick();
    Cancela = 1'b0;
    n_tests++;
    if (Etapa !== 3'd0 || Dosador_Cafe !== 1'b0 || Pronto !== 1'b0 || Ocupado !== 1'b0) begin
      n_fail++; $display("FAIL cancel_dosa: etapa=%0d cafe=%b pronto=%b ocup=%b expected 0 0 0 0",
                         Etapa, Dosador_Cafe, Pronto, Ocupado);
    end
    for (int k = 0; k < 4; k++) tick();
    n_tests++;
    if (Etapa !== 3'd0 || Pronto !== 1'b0) begin
      n_fail++; $display("FAIL cancel_no_restart: etapa=%0d pronto=%b expected 0 0", Etapa, Pronto);
    end
  endtask

  task automatic test_reset_mid_leite();
    iniciar(4'd4);
    for (int k = 0; k < 14; k++) tick();  // LEITE reached after 12, then 2 more
    n_tests++;
    if (Etapa !== 3'd4 || Valvula_Leite !== 1'b1 || Aquecedor !== 1'b0) begin
      n_fail++; $display("FAIL leite_active: etapa=%0d leite=%b aq=%b expected 4 1 0", Etapa, Valvula_Leite, Aquecedor);
    end
    #2;
    RST_N = 1'b0; Escolha = 2'b00;
    #1;
    n_tests++;
    if (saidas() !== 12'h000) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", saidas(), 12'h000);
    end
    #3;
    RST_N = 1'b1;
    tick();
    tick();
    n_tests++;
    if (Etapa !== 3'd0 || saidas() !== 12'h000) begin
      n_fail++; $display("FAIL post_reset_idle: got %h expected %h", saidas(), 12'h000);
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_invalid_code();
    test_espresso();
    test_milk_drinks();
    test_cha();
    test_aquec_timeout();
    test_copo_loss();
    test_cancel();
    test_reset_mid_leite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/controle_preparo.md
Name: controle_preparo

Overview:
- Brew sequencer downstream of the drink-selection FSM.
- Generates the selection-timeout pulse (Timer) that the selector consumes.
- On a confirmed choice, latches the 4-bit drink code and sequences heater, powder/tea doser, water valve and milk valve through a fixed recipe.
- Reports ready/busy/error to the panel.

Parameters:
- TIMEOUT_SEL, 64: cycles in "selecting" status before Timer asserts.
- T_PO, 3: doser-on cycles (coffee powder or tea).
- T_AGUA, 8: water-valve-on cycles.
- T_LEITE, 4: milk-valve-on cycles (cappuccino uses 2*T_LEITE).
- T_AQUEC_MAX, 32: max cycles waiting for Agua_Quente before error.
- T_PRONTO, 4: cycles Pronto is held high.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Escolha  in  2  selector status: 00 idle, 01 selecting, 10 timed out, 11 chosen.
- Bebida  in  4  selector display code: 1 espresso, 2 cafe com leite, 3 cha, 4 cappuccino.
- Agua_Quente  in  1  water-temperature-reached sensor.
- Copo  in  1  cup present.
- Cancela  in  1  user cancel / error acknowledge.
- Timer  out  1  selection timeout to selector.
- Aquecedor  out  1  heater on.
- Dosador_Cafe  out  1  coffee doser on.
- Dosador_Cha  out  1  tea doser on.
- Valvula_Agua  out  1  water valve open.
- Valvula_Leite  out  1  milk valve open.
- Ocupado  out  1  brew in progress.
- Pronto  out  1  drink finished.
- Erro  out  1  fault or timeout latched.
- Etapa  out  3  current state encoding, for display.

Behaviour:
- Reset (RST_N=0, async): state OCIOSO, all counters 0, latched code 0, every output 0.
- All outputs are registered; they reflect the state entered on the previous edge.
- Timer counter:
  - Counts only while Escolha==01 and state is OCIOSO; otherwise cleared to 0.
  - Timer=1 once count reaches TIMEOUT_SEL-1; stays 1 until Escolha!=01.
- Order start: rising detect of Escolha==11 (previous-cycle Escolha!=11) in OCIOSO latches Bebida.
  - A steady 11 never restarts a brew.
- States, Etapa values and transitions:
  - OCIOSO(000): start edge with code 1..4 -> AQUECE; code 0 or >4 -> ERRO; Escolha==10 -> ERRO.
  - AQUECE(001): Aquecedor=1, Ocupado=1. Agua_Quente=1 and Copo=1 -> DOSA. Wait counter reaching T_AQUEC_MAX -> ERRO. Copo=0 holds in AQUECE; the wait counter still runs.
  - DOSA(010): Dosador_Cha=1 for code 3, else Dosador_Cafe=1. Aquecedor stays 1. After T_PO cycles -> AGUA.
  - AGUA(011): Valvula_Agua=1, Aquecedor=1. After T_AGUA cycles: codes 2,4 -> LEITE; codes 1,3 -> PRONTO.
  - LEITE(100): Valvula_Leite=1, heater off. After T_LEITE cycles (code 2) or 2*T_LEITE cycles (code 4) -> PRONTO.
  - PRONTO(101): Pronto=1, Ocupado=0, all actuators off. After T_PRONTO cycles -> OCIOSO.
  - ERRO(110): Erro=1, all actuators off, Ocupado=0. Cancela=1 -> OCIOSO.
- Step counter: reloads to 0 on every state change; step length is exact (e.g. Valvula_Agua high exactly T_AGUA cycles).
- Safety in DOSA/AGUA/LEITE:
  - Copo=0 -> ERRO on the next edge; actuators drop that edge.
- Cancela:
  - In AQUECE/DOSA/AGUA/LEITE -> OCIOSO, actuators off next edge, no Pronto.
  - Ignored in PRONTO.
- Priority, highest first: RST_N, Copo loss, Cancela, step timer.
- After PRONTO or a cancel, a new order requires a fresh 0->11 edge on Escolha.

Test Plan:
- Escolha 00->01, held 64 cycles -> Timer=0 through cycle 62, Timer=1 from cycle 63; Escolha 10 -> ERRO, Erro=1; Cancela -> OCIOSO, Erro=0.
- Bebida=1, Escolha edge to 11, Agua_Quente=1 after 5 cycles, Copo=1 -> Dosador_Cafe 3 cycles, Valvula_Agua 8 cycles, no milk, Pronto 4 cycles, Etapa back to 000.
- Bebida=4 -> Valvula_Leite high exactly 8 cycles after water; Bebida=3 -> Dosador_Cha used and Dosador_Cafe never asserts.
- Agua_Quente held 0 -> ERRO after 32 cycles in AQUECE; Copo dropped mid-AGUA -> Valvula_Agua=0 and Erro=1 next edge.
- Escolha held at 11 after PRONTO -> no second brew; RST_N pulsed low mid-LEITE -> all outputs 0 immediately, state OCIOSO.
